// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory-interface slice.
package lc3_pkg;

   localparam int WORD_W = 16;

   // Memory-access FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // LDMDR control encodings; 2'b11 is reserved and behaves as HOLD
   typedef enum logic [1:0] {
      LDMDR_HOLD = 2'b00,
      LDMDR_BUS  = 2'b01,
      LDMDR_MEM  = 2'b10
   } ldmdr_t;

endpackage

// File: rtl/lc3_wait_timer.sv
// Counts unacknowledged access cycles; flags the cycle that would
// bring the count up to TIMEOUT so the FSM can abort on that edge.
module lc3_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Wait-cycle counter, cleared while no access is in flight
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 1'b1;
   end

   // The current unacked cycle is the TIMEOUT-th one
   assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory controller: loads MAR/MDR from the processor bus,
// runs single read/write accesses with ACK handshake and a wait timeout,
// and pulses R once when each access finishes (normally or by timeout).
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [WORD_W-1:0] BUS,
   input  logic              LDMAR,
   input  logic [1:0]        LDMDR,
   input  logic              MEM_RW,
   input  logic              GATE_MDR_SEL,
   output logic [WORD_W-1:0] MDR_OUT,
   output logic              R,
   output logic              ERR,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [WORD_W-1:0] MEM_ADDR,
   output logic [WORD_W-1:0] MEM_WDATA,
   input  logic [WORD_W-1:0] MEM_RDATA,
   input  logic              MEM_ACK
);

   state_t            state, state_nxt;
   logic [WORD_W-1:0] mar, mdr;
   logic              busy;
   logic              timer_clr, timer_en, expired;
   logic              timeout_hit;

   assign busy        = (state == ST_RD) || (state == ST_WR);
   assign timer_en    = busy && !MEM_ACK;
   assign timeout_hit = expired;   // expired already implies busy and no ACK

   lc3_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (expired)
   );

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; a write request beats a read request in the same cycle
   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            timer_clr = 1'b1;
            if (MEM_RW)
               state_nxt = ST_WR;
            else if (LDMDR == LDMDR_MEM)
               state_nxt = ST_RD;
         end
         ST_RD, ST_WR: begin
            if (MEM_ACK || timeout_hit)
               state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // MAR/MDR/ERR: bus loads only in IDLE, read data only on an acked read
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mar <= '0;
         mdr <= '0;
         ERR <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            if (LDMAR)
               mar <= BUS;
            if (LDMDR == LDMDR_BUS)
               mdr <= BUS;
         end
         if (state == ST_RD && MEM_ACK)
            mdr <= MEM_RDATA;
         if (timeout_hit)
            ERR <= 1'b1;
      end
   end

   // Outputs decode straight from state so reset kills the request at once
   assign MEM_REQ   = busy;
   assign MEM_WE    = (state == ST_WR);
   assign R         = (state == ST_DONE);
   assign MEM_ADDR  = mar;
   assign MEM_WDATA = mdr;
   assign MDR_OUT   = GATE_MDR_SEL ? mdr : '0;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl (TIMEOUT=4).
module tb_lc3_mem_ctrl;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [15:0] BUS;
   logic        LDMAR;
   logic [1:0]  LDMDR;
   logic        MEM_RW;
   logic        GATE_MDR_SEL;
   logic [15:0] MDR_OUT;
   logic        R, ERR, MEM_REQ, MEM_WE;
   logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic        MEM_ACK;

   int total = 0;
   int bad   = 0;

   lc3_mem_ctrl #(.TIMEOUT(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .BUS(BUS), .LDMAR(LDMAR), .LDMDR(LDMDR),
      .MEM_RW(MEM_RW), .GATE_MDR_SEL(GATE_MDR_SEL), .MDR_OUT(MDR_OUT), .R(R),
      .ERR(ERR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
   );

   always #5 CLK = ~CLK;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      LDMAR = 1'b0; LDMDR = 2'b00; MEM_RW = 1'b0; MEM_ACK = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; BUS = 16'hFFFF; GATE_MDR_SEL = 1'b1; MEM_RDATA = 16'h0;
      idle_inputs();
      #12;
      total++;
      if ({MEM_REQ, MEM_WE, R, ERR} !== 4'b0000 || MDR_OUT !== 16'h0 || MEM_ADDR !== 16'h0) begin
         bad++;
         $display("FAIL reset_outputs: req/we/r/err=%b mdr_out=%h addr=%h expected 0000/0000/0000",
                  {MEM_REQ, MEM_WE, R, ERR}, MDR_OUT, MEM_ADDR);
      end
      #3 RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_read();
      BUS = 16'h3000; LDMAR = 1'b1; LDMDR = 2'b10;
      tick();
      idle_inputs();
      total++;
      if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h3000) begin
         bad++;
         $display("FAIL read_issue: req=%b we=%b addr=%h expected 1 0 3000", MEM_REQ, MEM_WE, MEM_ADDR);
      end
      tick();
      MEM_ACK = 1'b1; MEM_RDATA = 16'h1234;
      tick();
      MEM_ACK = 1'b0; MEM_RDATA = 16'h0;
      total++;
      if (R !== 1'b1 || MEM_REQ !== 1'b0 || MDR_OUT !== 16'h1234) begin
         bad++;
         $display("FAIL read_done: r=%b req=%b mdr_out=%h expected 1 0 1234", R, MEM_REQ, MDR_OUT);
      end
      tick();
      total++;
      if (R !== 1'b0) begin
         bad++;
         $display("FAIL read_r_single: r=%b expected 0", R);
      end
      GATE_MDR_SEL = 1'b0;
      #1;
      total++;
      if (MDR_OUT !== 16'h0) begin
         bad++;
         $display("FAIL gate_off: mdr_out=%h expected 0000", MDR_OUT);
      end
      GATE_MDR_SEL = 1'b1;
   endtask

   task automatic test_write();
      BUS = 16'hBEEF; LDMDR = 2'b01;
      tick();
      LDMDR = 2'b00; MEM_RW = 1'b1;
      tick();
      MEM_RW = 1'b0;
      total++;
      if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_WDATA !== 16'hBEEF || MEM_ADDR !== 16'h3000) begin
         bad++;
         $display("FAIL write_issue: req=%b we=%b wdata=%h addr=%h expected 1 1 beef 3000",
                  MEM_REQ, MEM_WE, MEM_WDATA, MEM_ADDR);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_WDATA !== 16'hBEEF || R !== 1'b0) begin
            bad++;
            $display("FAIL write_wait%0d: req=%b we=%b wdata=%h r=%b expected 1 1 beef 0",
                     i, MEM_REQ, MEM_WE, MEM_WDATA, R);
         end
      end
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      total++;
      if (R !== 1'b1 || MEM_REQ !== 1'b0 || ERR !== 1'b0) begin
         bad++;
         $display("FAIL write_done: r=%b req=%b err=%b expected 1 0 0", R, MEM_REQ, ERR);
      end
      tick();
      total++;
      if (R !== 1'b0) begin
         bad++;
         $display("FAIL write_r_single: r=%b expected 0", R);
      end
   endtask

   task automatic test_timeout();
      LDMDR = 2'b10;
      tick();
      LDMDR = 2'b00;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (MEM_REQ !== 1'b1 || ERR !== 1'b0) begin
            bad++;
            $display("FAIL timeout_wait%0d: req=%b err=%b expected 1 0", i, MEM_REQ, ERR);
         end
         MEM_RDATA = 16'h5A5A;   // never acked, must not land in MDR
         tick();
      end
      total++;
      if (MEM_REQ !== 1'b0 || R !== 1'b1 || ERR !== 1'b1 || MDR_OUT !== 16'hBEEF) begin
         bad++;
         $display("FAIL timeout_abort: req=%b r=%b err=%b mdr_out=%h expected 0 1 1 beef",
                  MEM_REQ, R, ERR, MDR_OUT);
      end
      tick();
      total++;
      if (R !== 1'b0 || ERR !== 1'b1) begin
         bad++;
         $display("FAIL timeout_after: r=%b err=%b expected 0 1", R, ERR);
      end
   endtask

   task automatic test_simultaneous();
      BUS = 16'h4000; LDMAR = 1'b1; MEM_RW = 1'b1; LDMDR = 2'b10;
      tick();
      idle_inputs();
      total++;
      if (MEM_WE !== 1'b1 || MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h4000) begin
         bad++;
         $display("FAIL simul_write: we=%b req=%b addr=%h expected 1 1 4000", MEM_WE, MEM_REQ, MEM_ADDR);
      end
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      tick();
      total++;
      if (MEM_REQ !== 1'b0 || R !== 1'b0 || MDR_OUT !== 16'hBEEF) begin
         bad++;
         $display("FAIL simul_no_read: req=%b r=%b mdr_out=%h expected 0 0 beef", MEM_REQ, R, MDR_OUT);
      end
      // read, then try to disturb MAR/MDR while it is in flight
      LDMDR = 2'b10;
      tick();
      LDMAR = 1'b1; LDMDR = 2'b01; BUS = 16'h5555;
      tick();
      total++;
      if (MEM_ADDR !== 16'h4000 || MEM_REQ !== 1'b1 || MDR_OUT !== 16'hBEEF) begin
         bad++;
         $display("FAIL ldmar_in_rd: addr=%h req=%b mdr_out=%h expected 4000 1 beef",
                  MEM_ADDR, MEM_REQ, MDR_OUT);
      end
      LDMAR = 1'b0; LDMDR = 2'b00;
      MEM_ACK = 1'b1; MEM_RDATA = 16'hA5A5;
      tick();
      MEM_ACK = 1'b0;
      total++;
      if (R !== 1'b1 || MDR_OUT !== 16'hA5A5 || MEM_ADDR !== 16'h4000 || ERR !== 1'b1) begin
         bad++;
         $display("FAIL rd_after_ldmar: r=%b mdr_out=%h addr=%h err=%b expected 1 a5a5 4000 1",
                  R, MDR_OUT, MEM_ADDR, ERR);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      BUS = 16'h1111; LDMAR = 1'b1; LDMDR = 2'b10;
      tick();
      idle_inputs();
      total++;
      if (MEM_REQ !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_start: req=%b expected 1", MEM_REQ);
      end
      #2 RESET_N = 1'b0;
      #1;
      total++;
      if ({MEM_REQ, MEM_WE, R, ERR} !== 4'b0000 || MDR_OUT !== 16'h0 || MEM_ADDR !== 16'h0) begin
         bad++;
         $display("FAIL rst_mid_async: req/we/r/err=%b mdr_out=%h addr=%h expected 0000/0000/0000",
                  {MEM_REQ, MEM_WE, R, ERR}, MDR_OUT, MEM_ADDR);
      end
      #1 RESET_N = 1'b1;
      MEM_ACK = 1'b1; MEM_RDATA = 16'h7777;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (MEM_REQ !== 1'b0 || R !== 1'b0 || MDR_OUT !== 16'h0) begin
            bad++;
            $display("FAIL rst_late_ack%0d: req=%b r=%b mdr_out=%h expected 0 0 0000",
                     i, MEM_REQ, R, MDR_OUT);
         end
      end
      MEM_ACK = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_simultaneous();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles to wait for MEM_ACK before aborting.
REQ-002 SHALL have port CLK  in  1  single rising-edge clock.
REQ-003 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port BUS  in  16  processor data bus value.
REQ-005 SHALL have port LDMAR  in  1  load MAR from BUS.
REQ-006 SHALL have port LDMDR  in  2  with encoding 00 hold, 01 load MDR from BUS, 10 start memory read into MDR, 11 reserved (treated as hold).
REQ-007 SHALL have port MEM_RW  in  1  start a write of MDR to MEM[MAR].
REQ-008 SHALL have port GATE_MDR_SEL  in  1  drive MDR onto MDR_OUT.
REQ-009 SHALL have port MDR_OUT  out  16  MDR when GATE_MDR_SEL=1, otherwise 0.
REQ-010 SHALL have port R  out  1  one-cycle access-complete pulse to the control FSM.
REQ-011 SHALL have port ERR  out  1  sticky access-timeout flag.
REQ-012 SHALL have port MEM_REQ  out  1  memory request.
REQ-013 SHALL have port MEM_WE  out  1  write enable, valid while MEM_REQ=1.
REQ-014 SHALL have port MEM_ADDR  out  16  address, equal to MAR.
REQ-015 SHALL have port MEM_WDATA  out  16  write data, equal to MDR.
REQ-016 SHALL have port MEM_RDATA  in  16  read data, valid when MEM_ACK=1.
REQ-017 SHALL have port MEM_ACK  in  1  access acknowledge from memory.

Function
REQ-018 SHALL implement the states IDLE, RD, WR and DONE.
REQ-019 IDLE behaviour SHALL be:
  - LDMAR=1: MAR<=BUS.
  - LDMDR=01: MDR<=BUS.
  - LDMDR=10: go to RD.
  - MEM_RW=1: go to WR.
  - MEM_RW=1 and LDMDR=10 in the same cycle: WR wins and the read is dropped.
REQ-020 When LDMAR and an access start occur in the same cycle, the access SHALL use the new BUS value as its address.
REQ-021 In RD and WR, MEM_REQ SHALL be 1, MEM_WE SHALL be 1 only in WR, and MEM_ADDR/MEM_WDATA SHALL stay stable until the access ends.
REQ-022 In RD, when MEM_ACK is sampled 1: MDR<=MEM_RDATA, then go to DONE.
REQ-023 In WR, when MEM_ACK is sampled 1: go to DONE.
REQ-024 In DONE, R SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be: start at edge n gives MEM_REQ=1 in cycle n+1; ACK in cycle n+1 gives R=1 in cycle n+2.
REQ-026 A wait counter SHALL clear on access start and increment each RD/WR cycle without ACK.
REQ-027 When the wait counter reaches TIMEOUT:
  - MEM_REQ SHALL drop.
  - ERR<=1.
  - MDR SHALL be unchanged.
  - The FSM SHALL go to DONE, so R still pulses.
REQ-028 In RD, WR and DONE, LDMAR, LDMDR and MEM_RW SHALL be ignored, with MAR and MDR frozen except for the REQ-022 load.
REQ-029 MEM_ACK SHALL be ignored in IDLE and DONE.
REQ-030 MDR_OUT SHALL be combinational from GATE_MDR_SEL and MDR, with no added latency.
REQ-031 ERR SHALL clear only on reset.

Reset
REQ-032 RESET_N=0 SHALL asynchronously force:
  - state IDLE;
  - MAR, MDR and the wait counter to 0;
  - MEM_REQ, MEM_WE, R and ERR to 0;
  - MDR_OUT to 0.
REQ-033 Reset asserted mid-access SHALL abort the access immediately (MEM_REQ low in the same cycle), with no R pulse after release.

Structure
REQ-034 Package lc3_pkg SHALL hold the word width (16), the state encoding and the LDMDR encodings (HOLD, BUS, MEM).
REQ-035 The wait counter SHALL be one sub-module, lc3_wait_timer (clear, enable, TIMEOUT parameter, expired output); everything else SHALL be flat.

Verification
REQ-036 Read: MAR=0x3000, LDMDR=10, ACK one cycle after MEM_REQ with RDATA=0x1234 -> MDR=0x1234, R pulses once, MDR_OUT=0x1234 with gate=1.
REQ-037 Write: BUS=0xBEEF with LDMDR=01, then MEM_RW=1 -> MEM_WE=1, MEM_WDATA=0xBEEF, stable through 3 wait cycles until ACK; R pulses once.
REQ-038 Timeout: TIMEOUT=4, read with ACK never asserted -> MEM_REQ drops after 4 cycles, ERR=1 sticky, R pulses, MDR unchanged.
REQ-039 Simultaneous events:
  - LDMAR (BUS=0x4000) with MEM_RW=1 and LDMDR=10 -> write to 0x4000, no read issued.
  - LDMAR during RD -> MAR unchanged.
REQ-040 Reset mid-RD -> MEM_REQ=0 asynchronously, all outputs 0; a late ACK after release is ignored.
